// File: rtl/chip8_timers.sv
// CHIP-8 delay/sound timer unit: loadable 8-bit DT and ST counting down at TICK_HZ,
// with a square-wave beeper that runs while ST is non-zero.
module chip8_timers #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 60,
    parameter int TONE_HZ = 440
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] dataIn,
    input  logic       ldDelay,
    input  logic       ldSound,
    output logic [7:0] delayOut,
    output logic       soundOn,
    output logic       toneOut,
    output logic       tick
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int HALF = CLK_HZ / (2 * TONE_HZ);
    localparam int PC_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int TC_W = (HALF > 2) ? $clog2(HALF) : 1;
    localparam logic [PC_W-1:0] PC_MAX = PC_W'(DIV - 1);
    localparam logic [TC_W-1:0] TC_MAX = TC_W'(HALF - 1);

    if (DIV < 2 || HALF < 2) begin : g_bad_param
        $error("chip8_timers: DIV and HALF must both be >= 2");
    end

    logic [PC_W-1:0] pc_r;
    logic [TC_W-1:0] tc_r;
    logic [7:0]      dt_r;
    logic [7:0]      st_r;
    logic            sound_r;
    logic            tone_r;
    logic            tick_r;

    logic            tick_ev_s;
    logic [PC_W-1:0] pc_nxt_s;
    logic [TC_W-1:0] tc_nxt_s;
    logic [7:0]      dt_nxt_s;
    logic [7:0]      st_nxt_s;
    logic            tone_nxt_s;

    // Next-state logic: prescaler, timers (load > decrement > hold) and tone generator
    always_comb begin
        tick_ev_s  = en && (pc_r == PC_MAX);
        pc_nxt_s   = pc_r;
        dt_nxt_s   = dt_r;
        st_nxt_s   = st_r;
        tc_nxt_s   = tc_r;
        tone_nxt_s = tone_r;

        if (!en) begin
            pc_nxt_s = pc_r;
        end else if (tick_ev_s) begin
            pc_nxt_s = '0;
        end else begin
            pc_nxt_s = pc_r + PC_W'(1);
        end

        if (ldDelay) begin
            dt_nxt_s = dataIn;
        end else if (tick_ev_s && (dt_r != 8'd0)) begin
            dt_nxt_s = dt_r - 8'd1;
        end else begin
            dt_nxt_s = dt_r;
        end

        if (ldSound) begin
            st_nxt_s = dataIn;
        end else if (tick_ev_s && (st_r != 8'd0)) begin
            st_nxt_s = st_r - 8'd1;
        end else begin
            st_nxt_s = st_r;
        end

        // Silencing rephases the tone so the next beep starts with a full low half-period
        if (st_nxt_s == 8'd0) begin
            tc_nxt_s   = '0;
            tone_nxt_s = 1'b0;
        end else if (sound_r && en) begin
            if (tc_r == TC_MAX) begin
                tc_nxt_s   = '0;
                tone_nxt_s = ~tone_r;
            end else begin
                tc_nxt_s   = tc_r + TC_W'(1);
                tone_nxt_s = tone_r;
            end
        end else begin
            tc_nxt_s   = tc_r;
            tone_nxt_s = tone_r;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r    <= '0;
            tc_r    <= '0;
            dt_r    <= 8'd0;
            st_r    <= 8'd0;
            sound_r <= 1'b0;
            tone_r  <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            pc_r    <= pc_nxt_s;
            tc_r    <= tc_nxt_s;
            dt_r    <= dt_nxt_s;
            st_r    <= st_nxt_s;
            sound_r <= (st_nxt_s != 8'd0);
            tone_r  <= tone_nxt_s;
            tick_r  <= tick_ev_s;
        end
    end

    assign delayOut = dt_r;
    assign soundOn  = sound_r;
    assign toneOut  = tone_r;
    assign tick     = tick_r;

endmodule

// File: tb/tb_chip8_timers.sv
// Directed bench for chip8_timers with CLK_HZ=600, TICK_HZ=60, TONE_HZ=60 (DIV=10, HALF=5).
module tb_chip8_timers;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [7:0] dataIn = 8'd0;
    logic       ldDelay = 1'b0;
    logic       ldSound = 1'b0;
    logic [7:0] delayOut;
    logic       soundOn;
    logic       toneOut;
    logic       tick;

    int n_cmp = 0;
    int n_bad = 0;
    int pcm   = 0;

    chip8_timers #(.CLK_HZ(600), .TICK_HZ(60), .TONE_HZ(60)) dut (
        .clk(clk), .rst(rst), .en(en), .dataIn(dataIn),
        .ldDelay(ldDelay), .ldSound(ldSound),
        .delayOut(delayOut), .soundOn(soundOn), .toneOut(toneOut), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one clock; sample 1 time unit after the edge; track expected prescaler phase
    task automatic cyc();
        @(posedge clk);
        #1;
        if (en) pcm = (pcm + 1) % 10;
    endtask

    task automatic align(input int target);
        while (pcm != target) cyc();
    endtask

    task automatic load(input logic d, input logic s, input logic [7:0] v);
        ldDelay = d;
        ldSound = s;
        dataIn  = v;
        cyc();
        ldDelay = 1'b0;
        ldSound = 1'b0;
    endtask

    initial begin
        int n;
        #1 rst = 1'b0;
        #2;
        chk("rst_delay", delayOut, 8'd0);
        chk("rst_sound", {7'd0, soundOn}, 8'd0);
        chk("rst_tone", {7'd0, toneOut}, 8'd0);
        chk("rst_tick", {7'd0, tick}, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        pcm = 0;

        // 1. reset mid-count
        load(1'b1, 1'b0, 8'd7);
        load(1'b0, 1'b1, 8'd3);
        repeat (11) cyc();
        chk("t1_pre_delay", delayOut, 8'd6);
        chk("t1_pre_sound", {7'd0, soundOn}, 8'd1);
        #3 rst = 1'b0;
        #1;
        chk("t1_async_delay", delayOut, 8'd0);
        chk("t1_async_sound", {7'd0, soundOn}, 8'd0);
        chk("t1_async_tone", {7'd0, toneOut}, 8'd0);
        chk("t1_async_tick", {7'd0, tick}, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        pcm = 0;
        for (int k = 1; k <= 11; k++) begin
            cyc();
            chk($sformatf("t1_tick_c%0d", k), {7'd0, tick}, (k == 10) ? 8'd1 : 8'd0);
        end

        // 2. basic decrement
        align(0);
        load(1'b1, 1'b0, 8'd3);
        chk("t2_load", delayOut, 8'd3);
        repeat (8) cyc();
        chk("t2_hold", delayOut, 8'd3);
        chk("t2_notick", {7'd0, tick}, 8'd0);
        cyc();
        chk("t2_dec2", delayOut, 8'd2);
        chk("t2_tick", {7'd0, tick}, 8'd1);
        repeat (10) cyc();
        chk("t2_dec1", delayOut, 8'd1);
        repeat (10) cyc();
        chk("t2_dec0", delayOut, 8'd0);
        repeat (50) cyc();
        chk("t2_sat", delayOut, 8'd0);

        // 3. load on the tick edge: load wins
        align(9);
        load(1'b1, 1'b0, 8'd5);
        chk("t3_load_wins", delayOut, 8'd5);
        chk("t3_tick", {7'd0, tick}, 8'd1);
        repeat (9) cyc();
        chk("t3_hold", delayOut, 8'd5);
        cyc();
        chk("t3_dec", delayOut, 8'd4);

        // 4. sound with ST=2
        align(0);
        load(1'b0, 1'b1, 8'd2);
        chk("t4_on", {7'd0, soundOn}, 8'd1);
        chk("t4_tone_lo0", {7'd0, toneOut}, 8'd0);
        repeat (4) cyc();
        chk("t4_tone_lo4", {7'd0, toneOut}, 8'd0);
        cyc();
        chk("t4_tone_hi", {7'd0, toneOut}, 8'd1);
        repeat (4) cyc();
        chk("t4_tone_hi4", {7'd0, toneOut}, 8'd1);
        chk("t4_on_st1", {7'd0, soundOn}, 8'd1);
        cyc();
        chk("t4_tone_lo", {7'd0, toneOut}, 8'd0);
        repeat (8) cyc();
        chk("t4_tone_hi2", {7'd0, toneOut}, 8'd1);
        chk("t4_on_last", {7'd0, soundOn}, 8'd1);
        cyc();
        chk("t4_off_sound", {7'd0, soundOn}, 8'd0);
        chk("t4_off_tone", {7'd0, toneOut}, 8'd0);

        // 5. pause
        align(2);
        load(1'b1, 1'b0, 8'd4);
        en = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (i == 10) begin
                ldSound = 1'b1;
                dataIn  = 8'd9;
            end
            cyc();
            ldSound = 1'b0;
            chk($sformatf("t5_notick_%0d", i), {7'd0, tick}, 8'd0);
            chk($sformatf("t5_hold_%0d", i), delayOut, 8'd4);
        end
        chk("t5_on", {7'd0, soundOn}, 8'd1);
        chk("t5_tone_frozen", {7'd0, toneOut}, 8'd0);
        en = 1'b1;
        repeat (6) cyc();
        chk("t5_resume_hold", delayOut, 8'd4);
        chk("t5_resume_notick", {7'd0, tick}, 8'd0);
        chk("t5_resume_tone", {7'd0, toneOut}, 8'd1);
        cyc();
        chk("t5_resume_dec", delayOut, 8'd3);
        chk("t5_resume_tick", {7'd0, tick}, 8'd1);

        // 6. silence by loading 0
        load(1'b0, 1'b1, 8'd200);
        chk("t6_on", {7'd0, soundOn}, 8'd1);
        n = 0;
        while (toneOut !== 1'b1 && n < 10) begin
            cyc();
            n++;
        end
        chk("t6_tone_hi", {7'd0, toneOut}, 8'd1);
        load(1'b0, 1'b1, 8'd0);
        chk("t6_sil_sound", {7'd0, soundOn}, 8'd0);
        chk("t6_sil_tone", {7'd0, toneOut}, 8'd0);
        repeat (3) cyc();
        chk("t6_sil_stay", {7'd0, toneOut}, 8'd0);
        align(0);
        load(1'b0, 1'b1, 8'd1);
        chk("t6_re_on", {7'd0, soundOn}, 8'd1);
        chk("t6_re_lo", {7'd0, toneOut}, 8'd0);
        repeat (4) cyc();
        chk("t6_re_lo4", {7'd0, toneOut}, 8'd0);
        cyc();
        chk("t6_re_hi", {7'd0, toneOut}, 8'd1);
        repeat (4) cyc();
        chk("t6_re_end_sound", {7'd0, soundOn}, 8'd0);
        chk("t6_re_end_tone", {7'd0, toneOut}, 8'd0);

        // simultaneous loads share dataIn
        load(1'b1, 1'b1, 8'd6);
        chk("both_delay", delayOut, 8'd6);
        chk("both_sound", {7'd0, soundOn}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
